// File: rtl/tlu_pkg.sv
// Shared state encoding and handshake-mode constants for the TLU trigger interface.
package tlu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOW,
    ST_SHIFT,
    ST_DELIVER,
    ST_HOLD
  } state_t;

  localparam logic [1:0] MODE_NOHS   = 2'd0;
  localparam logic [1:0] MODE_SIMPLE = 2'd1;
  localparam logic [1:0] MODE_DATA   = 2'd2;

  // The reserved encoding 3 falls back to the simple handshake.
  function automatic logic [1:0] map_mode(input logic [1:0] m);
    return (m == MODE_NOHS || m == MODE_DATA) ? m : MODE_SIMPLE;
  endfunction

endpackage

// File: rtl/tlu_tclk_gen.sv
// Registered TLU trigger-clock generator: TID_WIDTH periods of 2*TCLK_HALF cycles,
// starting high, with a sample strobe on the last low-phase cycle of each period.
module tlu_tclk_gen #(
  parameter int TCLK_HALF = 4,
  parameter int TID_WIDTH = 16,
  parameter int BW        = (TID_WIDTH > 1) ? $clog2(TID_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          tclk,
  output logic          sample,
  output logic          done,
  output logic [BW-1:0] bit_idx
);

  localparam int            CW       = $clog2(2 * TCLK_HALF);
  localparam logic [CW-1:0] CNT_FALL = CW'(TCLK_HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * TCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(TID_WIDTH - 1);

  logic          run_q, run_d;
  logic          tclk_q, tclk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;

  assign sample  = run_q && (cnt_q == CNT_LAST);
  assign done    = sample && (bit_q == BIT_LAST);
  assign tclk    = tclk_q;
  assign bit_idx = bit_q;

  always_comb begin
    run_d  = run_q;
    tclk_d = tclk_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    if (abort) begin
      run_d  = 1'b0;
      tclk_d = 1'b0;
      cnt_d  = '0;
      bit_d  = '0;
    end else if (start) begin
      run_d  = 1'b1;
      tclk_d = 1'b1;
      cnt_d  = '0;
      bit_d  = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_FALL) tclk_d = 1'b0;
      if (sample) begin
        cnt_d = '0;
        if (done) begin
          run_d  = 1'b0;
          tclk_d = 1'b0;
        end else begin
          bit_d  = bit_q + 1'b1;
          tclk_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      tclk_q <= 1'b0;
      cnt_q  <= '0;
      bit_q  <= '0;
    end else begin
      run_q  <= run_d;
      tclk_q <= tclk_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/tlu_trigger_ctrl.sv
// TLU trigger interface: synchronised trigger input, no-handshake / simple / trigger-data
// handshakes with timeout and DUT-busy extension, and a valid/ready trigger-ID stream.
module tlu_trigger_ctrl
  import tlu_pkg::*;
#(
  parameter int TID_WIDTH = 16,
  parameter int TCLK_HALF = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  input  logic [1:0]           MODE,
  input  logic                 TRIGGER,
  input  logic                 DUT_BUSY,
  output logic                 BUSY,
  output logic                 TRIGGER_CLOCK,
  output logic                 TRIG_VALID,
  input  logic                 TRIG_READY,
  output logic [TID_WIDTH-1:0] TRIG_ID,
  output logic                 TRIG_TIMEOUT,
  output logic [15:0]          DROP_CNT
);

  localparam int            BW       = (TID_WIDTH > 1) ? $clog2(TID_WIDTH) : 1;
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic                 sync1_q, trig_s_q, trig_prev_q;
  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [TID_WIDTH-1:0] int_cnt_q, int_cnt_d;
  logic [TID_WIDTH-1:0] sr_q, sr_d;
  logic [TID_WIDTH-1:0] id_q, id_d;
  logic                 valid_q, valid_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic                 busy_q, busy_d;
  logic [15:0]          drop_q, drop_d;

  logic          trig_edge, tmo_hit, xfer;
  logic          gen_start, gen_abort, sample, done;
  logic [BW-1:0] bit_idx;

  assign trig_edge = trig_s_q & ~trig_prev_q;
  assign tmo_hit   = (state_q == ST_WAIT_LOW || state_q == ST_SHIFT) && (tmo_q == TMO_LAST);
  assign xfer      = valid_q & TRIG_READY;
  assign gen_start = (state_q == ST_IDLE) && (state_d == ST_SHIFT);
  assign gen_abort = (state_q == ST_SHIFT) && tmo_hit;

  tlu_tclk_gen #(
    .TCLK_HALF (TCLK_HALF),
    .TID_WIDTH (TID_WIDTH),
    .BW        (BW)
  ) u_tclk_gen (
    .clk     (CLK),
    .rst_n   (RST_N),
    .start   (gen_start),
    .abort   (gen_abort),
    .tclk    (TRIGGER_CLOCK),
    .sample  (sample),
    .done    (done),
    .bit_idx (bit_idx)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tmo_d      = '0;
    int_cnt_d  = int_cnt_q;
    sr_d       = sr_q;
    id_d       = id_q;
    valid_d    = valid_q;
    tmo_flag_d = tmo_flag_q;
    drop_d     = drop_q;
    busy_d     = 1'b0;
    for (int i = 0; i < TID_WIDTH; i++) begin
      if (sample && bit_idx == BW'(i)) sr_d[i] = trig_s_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (ENABLE && trig_edge) begin
          mode_d = map_mode(MODE);
          case (mode_d)
            MODE_NOHS: begin
              state_d    = ST_DELIVER;
              valid_d    = 1'b1;
              id_d       = int_cnt_q;
              tmo_flag_d = 1'b0;
              int_cnt_d  = int_cnt_q + 1'b1;
            end
            MODE_DATA: begin
              state_d = ST_SHIFT;
              sr_d    = '0;
            end
            default: state_d = ST_WAIT_LOW;
          endcase
        end
      end
      ST_WAIT_LOW: begin
        tmo_d = tmo_q + 1'b1;
        if (!trig_s_q || tmo_hit) begin
          state_d    = ST_DELIVER;
          valid_d    = 1'b1;
          id_d       = int_cnt_q;
          tmo_flag_d = trig_s_q;
          int_cnt_d  = int_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        tmo_d = tmo_q + 1'b1;
        // sr_d already holds the bit sampled this cycle, so the last bit is not lost.
        if (done || tmo_hit) begin
          state_d    = ST_DELIVER;
          valid_d    = 1'b1;
          id_d       = sr_d;
          tmo_flag_d = !done;
        end
      end
      ST_DELIVER: begin
        if (mode_q == MODE_NOHS) begin
          if (ENABLE && trig_edge) begin
            if (xfer) begin
              id_d       = int_cnt_q;
              tmo_flag_d = 1'b0;
              int_cnt_d  = int_cnt_q + 1'b1;
            end else if (drop_q != 16'hFFFF) begin
              drop_d = drop_q + 16'd1;
            end
          end else if (xfer) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (xfer) begin
          valid_d = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!DUT_BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_IDLE:    busy_d = DUT_BUSY;
      ST_DELIVER: busy_d = (mode_d != MODE_NOHS);
      default:    busy_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NOHS;
      tmo_q       <= '0;
      int_cnt_q   <= '0;
      sr_q        <= '0;
      id_q        <= '0;
      valid_q     <= 1'b0;
      tmo_flag_q  <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      sync1_q     <= TRIGGER;
      trig_s_q    <= sync1_q;
      trig_prev_q <= trig_s_q;
      state_q     <= state_d;
      mode_q      <= mode_d;
      tmo_q       <= tmo_d;
      int_cnt_q   <= int_cnt_d;
      sr_q        <= sr_d;
      id_q        <= id_d;
      valid_q     <= valid_d;
      tmo_flag_q  <= tmo_flag_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign BUSY         = busy_q;
  assign TRIG_VALID   = valid_q;
  assign TRIG_ID      = id_q;
  assign TRIG_TIMEOUT = tmo_flag_q;
  assign DROP_CNT     = drop_q;

endmodule

// File: tb/tb_tlu_trigger_ctrl.sv
// Directed bench for tlu_trigger_ctrl: a main instance (TCLK_HALF=4) and a short-timeout
// instance (TCLK_HALF=16, TIMEOUT=200) driven by a simple TLU model.
module tb_tlu_trigger_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        dut_busy;
  logic        ready;

  logic        en_a, trig_a, busy_a, tclk_a, valid_a, tmo_a;
  logic [15:0] id_a, drop_a;
  logic        en_b, trig_b, busy_b, tclk_b, valid_b, tmo_b;
  logic [15:0] id_b, drop_b;

  int checks = 0;
  int errors = 0;

  tlu_trigger_ctrl #(.TID_WIDTH(16), .TCLK_HALF(4), .TIMEOUT(1023)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en_a), .MODE(mode), .TRIGGER(trig_a),
    .DUT_BUSY(dut_busy), .BUSY(busy_a), .TRIGGER_CLOCK(tclk_a), .TRIG_VALID(valid_a),
    .TRIG_READY(ready), .TRIG_ID(id_a), .TRIG_TIMEOUT(tmo_a), .DROP_CNT(drop_a)
  );

  tlu_trigger_ctrl #(.TID_WIDTH(16), .TCLK_HALF(16), .TIMEOUT(200)) dut_t (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en_b), .MODE(mode), .TRIGGER(trig_b),
    .DUT_BUSY(dut_busy), .BUSY(busy_b), .TRIGGER_CLOCK(tclk_b), .TRIG_VALID(valid_b),
    .TRIG_READY(ready), .TRIG_ID(id_b), .TRIG_TIMEOUT(tmo_b), .DROP_CNT(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid_a(output bit got);
    int n;
    n = 0;
    got = 1'b0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (valid_a) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // TLU model: trigger high, then one data bit per rising TRIGGER_CLOCK, LSB first.
  task automatic shift_a(input logic [15:0] data, input int stop_rise, output int rises,
                         output int first_rise, output int last_rise, output bit got);
    int n;
    logic prev;
    rises = 0; first_rise = 0; last_rise = 0; got = 1'b0; prev = 1'b0; n = 0;
    trig_a = 1'b1;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (valid_a) begin
        got = 1'b1;
        break;
      end
      if (tclk_a && !prev) begin
        rises++;
        if (rises == 1) first_rise = n;
        last_rise = n;
        if (rises == stop_rise) break;
        trig_a = data[rises-1];
      end
      prev = tclk_a;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (tclk_a !== 1'b0) begin errors++; $display("FAIL reset_tclk: got %b expected 0", tclk_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    checks++; if (id_a !== 16'h0) begin errors++; $display("FAIL reset_id: got %h expected 0000", id_a); end
    checks++; if (drop_a !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h expected 0000", drop_a); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_mode1;
    int lat;
    bit got;
    do_reset();
    mode = 2'd1; en_a = 1'b1; ready = 1'b0; dut_busy = 1'b0;
    trig_a = 1'b1;
    lat = 0;
    while (!busy_a && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (!busy_a || lat > 4) begin errors++; $display("FAIL m1_busy_latency: got %0d cycles expected <=4", lat); end
    for (int i = lat; i < 40; i++) begin
      @(negedge clk);
      checks++; if (busy_a !== 1'b1 || valid_a !== 1'b0) begin errors++; $display("FAIL m1_wait_low: busy=%b valid=%b expected busy=1 valid=0", busy_a, valid_a); end
    end
    trig_a = 1'b0;
    wait_valid_a(got);
    checks++; if (!got) begin errors++; $display("FAIL m1_valid: got no word expected one"); end
    checks++; if (id_a !== 16'd0) begin errors++; $display("FAIL m1_id0: got %h expected 0000", id_a); end
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL m1_tmo0: got %b expected 0", tmo_a); end
    repeat (3) @(negedge clk);
    checks++; if (valid_a !== 1'b1 || id_a !== 16'd0 || busy_a !== 1'b1) begin errors++; $display("FAIL m1_hold_word: valid=%b id=%h busy=%b expected 1/0000/1", valid_a, id_a, busy_a); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL m1_consumed: valid got %b expected 0", valid_a); end
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL m1_busy_release: got %b expected 0", busy_a); end
    trig_a = 1'b1;
    repeat (6) @(negedge clk);
    trig_a = 1'b0;
    wait_valid_a(got);
    checks++; if (!got || id_a !== 16'd1) begin errors++; $display("FAIL m1_id1: got %h (valid %b) expected 0001", id_a, got); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    $display("test_mode1 done");
  endtask

  task automatic test_mode2_data;
    int rises, first_rise, last_rise;
    bit got;
    do_reset();
    mode = 2'd2; en_a = 1'b1; en_b = 1'b0; ready = 1'b0; dut_busy = 1'b0;
    shift_a(16'hA5C3, 0, rises, first_rise, last_rise, got);
    checks++; if (!got) begin errors++; $display("FAIL m2_valid: got no word expected one"); end
    checks++; if (rises != 16) begin errors++; $display("FAIL m2_periods: got %0d expected 16", rises); end
    checks++; if (last_rise - first_rise != 120) begin errors++; $display("FAIL m2_period_len: got %0d expected 120", last_rise - first_rise); end
    checks++; if (id_a !== 16'hA5C3) begin errors++; $display("FAIL m2_id: got %h expected a5c3", id_a); end
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL m2_tmo: got %b expected 0", tmo_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL m2_busy_deliver: got %b expected 1", busy_a); end
    checks++; if (tclk_a !== 1'b0) begin errors++; $display("FAIL m2_tclk_idle: got %b expected 0", tclk_a); end
    trig_a = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL m2_busy_release: got %b expected 0", busy_a); end
    $display("test_mode2_data done");
  endtask

  task automatic test_mode2_timeout;
    int n, busy_at, rises;
    bit got, seen;
    logic prev;
    logic [15:0] data;
    data = 16'hA5ED;
    en_a = 1'b0; en_b = 1'b1; mode = 2'd2; ready = 1'b0; dut_busy = 1'b0;
    n = 0; busy_at = 0; rises = 0; got = 1'b0; seen = 1'b0; prev = 1'b0;
    trig_b = 1'b1;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (valid_b) begin
        got = 1'b1;
        break;
      end
      if (busy_b && !seen) begin
        seen = 1'b1;
        busy_at = n;
      end
      if (tclk_b && !prev) begin
        rises++;
        trig_b = (rises <= 6) ? data[rises-1] : 1'b0;
      end
      prev = tclk_b;
    end
    checks++; if (!got) begin errors++; $display("FAIL m2to_valid: got no word expected one"); end
    checks++; if (n - busy_at != 200) begin errors++; $display("FAIL m2to_abort_cycle: got %0d expected 200", n - busy_at); end
    checks++; if (tmo_b !== 1'b1) begin errors++; $display("FAIL m2to_flag: got %b expected 1", tmo_b); end
    checks++; if (id_b !== 16'h002D) begin errors++; $display("FAIL m2to_partial_id: got %h expected 002d", id_b); end
    checks++; if (tclk_b !== 1'b0) begin errors++; $display("FAIL m2to_tclk: got %b expected 0", tclk_b); end
    checks++; if (rises != 7) begin errors++; $display("FAIL m2to_periods: got %0d expected 7", rises); end
    trig_b = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    en_b = 1'b0;
    $display("test_mode2_timeout done");
  endtask

  task automatic test_mode0;
    bit busy_seen;
    do_reset();
    mode = 2'd0; en_a = 1'b1; ready = 1'b0; dut_busy = 1'b0; busy_seen = 1'b0;
    for (int p = 0; p < 3; p++) begin
      trig_a = 1'b1;
      repeat (4) begin @(negedge clk); busy_seen |= busy_a; end
      trig_a = 1'b0;
      repeat (4) begin @(negedge clk); busy_seen |= busy_a; end
    end
    checks++; if (valid_a !== 1'b1 || id_a !== 16'd0) begin errors++; $display("FAIL m0_first_word: valid=%b id=%h expected 1/0000", valid_a, id_a); end
    checks++; if (drop_a !== 16'd2) begin errors++; $display("FAIL m0_drop_cnt: got %0d expected 2", drop_a); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL m0_busy: got %b expected 0", busy_seen); end
    // Edge detected in the same cycle as the transfer: accepted, not dropped.
    trig_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid_a !== 1'b1 || id_a !== 16'd1) begin errors++; $display("FAIL m0_xfer_and_edge: valid=%b id=%h expected 1/0001", valid_a, id_a); end
    checks++; if (drop_a !== 16'd2) begin errors++; $display("FAIL m0_xfer_no_drop: got %0d expected 2", drop_a); end
    trig_a = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL m0_drain: valid got %b expected 0", valid_a); end
    $display("test_mode0 done");
  endtask

  task automatic test_dut_busy;
    bit got;
    do_reset();
    mode = 2'd1; en_a = 1'b1; ready = 1'b0; dut_busy = 1'b0;
    trig_a = 1'b1;
    repeat (5) @(negedge clk);
    trig_a = 1'b0;
    wait_valid_a(got);
    checks++; if (!got || id_a !== 16'd0) begin errors++; $display("FAIL db_word: id=%h valid=%b expected 0000/1", id_a, got); end
    dut_busy = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL db_extend: cycle %0d got %b expected 1", i, busy_a); end
      @(negedge clk);
    end
    dut_busy = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL db_before_fall: got %b expected 1", busy_a); end
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL db_after_fall: got %b expected 0", busy_a); end
    repeat (2) @(negedge clk);
    $display("test_dut_busy done");
  endtask

  task automatic test_reset_mid_shift;
    int rises, first_rise, last_rise;
    bit got;
    do_reset();
    mode = 2'd2; en_a = 1'b1; ready = 1'b0; dut_busy = 1'b0;
    shift_a(16'h3C5A, 8, rises, first_rise, last_rise, got);
    checks++; if (rises != 8) begin errors++; $display("FAIL rst_reach_bit7: got %0d rises expected 8", rises); end
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b expected 1", busy_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0 || tclk_a !== 1'b0 || valid_a !== 1'b0) begin errors++; $display("FAIL rst_async_outputs: busy=%b tclk=%b valid=%b expected 0/0/0", busy_a, tclk_a, valid_a); end
    checks++; if (id_a !== 16'h0 || tmo_a !== 1'b0 || drop_a !== 16'h0) begin errors++; $display("FAIL rst_async_data: id=%h tmo=%b drop=%h expected 0", id_a, tmo_a, drop_a); end
    @(negedge clk);
    trig_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    shift_a(16'h5A3C, 0, rises, first_rise, last_rise, got);
    checks++; if (!got || rises != 16) begin errors++; $display("FAIL rst_restart: valid=%b rises=%0d expected 1/16", got, rises); end
    checks++; if (id_a !== 16'h5A3C || tmo_a !== 1'b0) begin errors++; $display("FAIL rst_restart_id: id=%h tmo=%b expected 5a3c/0", id_a, tmo_a); end
    trig_a = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    $display("test_reset_mid_shift done");
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; dut_busy = 1'b0; ready = 1'b0;
    en_a = 1'b0; trig_a = 1'b0; en_b = 1'b0; trig_b = 1'b0;
    test_reset();
    test_mode1();
    test_mode2_data();
    test_mode2_timeout();
    test_mode0();
    test_dut_busy();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
